// File: rtl/mc_pad_bank_ctrl.sv
`default_nettype none
// ============================================================================
// mc_pad_bank_ctrl : GPIO pad-bank controller (drive modes, input sync,
//                    debounce, edge interrupts with W1C status)
// Revision: 1.0
// ============================================================================
module mc_pad_bank_ctrl #(
    parameter int                     NumChannels = 16,
    parameter int                     SyncStages  = 2,
    parameter int                     DbCntWidth  = 8,
    parameter logic [NumChannels-1:0] ResetOe     = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [2:0]             addr_i,
    input  logic [31:0]            wdata_i,
    output logic                   gnt_o,
    output logic                   rvalid_o,
    output logic [31:0]            rdata_o,
    output logic [NumChannels-1:0] pad_out_o,
    output logic [NumChannels-1:0] pad_oe_o,
    input  logic [NumChannels-1:0] pad_in_i,
    output logic                   irq_o
);

    localparam logic [2:0] c_ADDR_OUT  = 3'd0;
    localparam logic [2:0] c_ADDR_OE   = 3'd1;
    localparam logic [2:0] c_ADDR_OD   = 3'd2;
    localparam logic [2:0] c_ADDR_IN   = 3'd3;
    localparam logic [2:0] c_ADDR_RISE = 3'd4;
    localparam logic [2:0] c_ADDR_FALL = 3'd5;
    localparam logic [2:0] c_ADDR_STAT = 3'd6;
    localparam logic [2:0] c_ADDR_DEB  = 3'd7;

    logic [NumChannels-1:0] r_out, r_oe, r_od, r_rise, r_fall, r_irq_st;
    logic [DbCntWidth-1:0]  r_deb;
    logic                   r_rvalid;
    logic [31:0]            r_rdata;
    logic                   r_irq;

    logic [NumChannels-1:0] r_sync [SyncStages];
    logic [NumChannels-1:0] r_filt;
    logic [DbCntWidth-1:0]  r_cnt  [NumChannels];

    logic                   w_wr;
    logic [31:0]            w_rdata;
    logic [NumChannels-1:0] w_sync;
    logic [NumChannels-1:0] w_filt_nxt;
    logic [NumChannels-1:0] w_set;
    logic [NumChannels-1:0] w_clr;
    logic                   w_unused_wdata;

    assign w_wr           = req_i & we_i;
    assign w_sync         = r_sync[SyncStages-1];
    assign w_unused_wdata = ^wdata_i;

    always_comb begin
        w_rdata = '0;
        case (addr_i)
            c_ADDR_OUT:  w_rdata[NumChannels-1:0] = r_out;
            c_ADDR_OE:   w_rdata[NumChannels-1:0] = r_oe;
            c_ADDR_OD:   w_rdata[NumChannels-1:0] = r_od;
            c_ADDR_IN:   w_rdata[NumChannels-1:0] = r_filt;
            c_ADDR_RISE: w_rdata[NumChannels-1:0] = r_rise;
            c_ADDR_FALL: w_rdata[NumChannels-1:0] = r_fall;
            c_ADDR_STAT: w_rdata[NumChannels-1:0] = r_irq_st;
            c_ADDR_DEB:  w_rdata[DbCntWidth-1:0]  = r_deb;
            default:     w_rdata = '0;
        endcase
    end

    // Filter flips only once the synced value has disagreed for DEBOUNCE+1 edges
    always_comb begin
        w_filt_nxt = r_filt;
        for (int i = 0; i < NumChannels; i++) begin
            if ((w_sync[i] != r_filt[i]) && (r_cnt[i] == r_deb)) begin
                w_filt_nxt[i] = w_sync[i];
            end
        end
    end

    assign w_set = (w_filt_nxt & ~r_filt & r_rise) | (~w_filt_nxt & r_filt & r_fall);
    assign w_clr = (w_wr && (addr_i == c_ADDR_STAT)) ? wdata_i[NumChannels-1:0] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out    <= '0;
            r_oe     <= ResetOe;
            r_od     <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_irq_st <= '0;
            r_deb    <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr) begin
                case (addr_i)
                    c_ADDR_OUT:  r_out  <= wdata_i[NumChannels-1:0];
                    c_ADDR_OE:   r_oe   <= wdata_i[NumChannels-1:0];
                    c_ADDR_OD:   r_od   <= wdata_i[NumChannels-1:0];
                    c_ADDR_RISE: r_rise <= wdata_i[NumChannels-1:0];
                    c_ADDR_FALL: r_fall <= wdata_i[NumChannels-1:0];
                    c_ADDR_DEB:  r_deb  <= wdata_i[DbCntWidth-1:0];
                    default:     ;
                endcase
            end
            // A new edge event beats a same-cycle W1C on the same bit
            r_irq_st <= (r_irq_st & ~w_clr) | w_set;
            r_irq    <= |(r_irq_st & (r_rise | r_fall));
            r_rvalid <= req_i;
            r_rdata  <= req_i ? w_rdata : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SyncStages; s++) begin
                r_sync[s] <= '0;
            end
            for (int i = 0; i < NumChannels; i++) begin
                r_cnt[i] <= '0;
            end
            r_filt <= '0;
        end else begin
            r_sync[0] <= pad_in_i;
            for (int s = 1; s < SyncStages; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            for (int i = 0; i < NumChannels; i++) begin
                if (w_sync[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == r_deb) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DbCntWidth'(1);
                end
            end
            r_filt <= w_filt_nxt;
        end
    end

    assign gnt_o     = 1'b1;
    assign rvalid_o  = r_rvalid;
    assign rdata_o   = r_rdata;
    assign irq_o     = r_irq;
    assign pad_out_o = r_out & ~r_od;
    assign pad_oe_o  = r_oe & ~(r_od & r_out);

endmodule
`default_nettype wire
